uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 4; the number of baud_tick pulses per serial bit (range 2..16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4; the transmit FIFO entry count (power of two, 2..16).
REQ-003 SHALL have parameter STOP_BITS, default 1; the number of stop bits (1 or 2).
REQ-004 SHALL have port clk, input, 1 bit: system clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port baud_tick, input, 1 bit: single-cycle enable at OVERSAMPLE x bit rate; the same tick that drives the receiver.
REQ-007 SHALL have port tx_data, input, 8 bits: byte to queue.
REQ-008 SHALL have port tx_valid, input, 1 bit: tx_data is valid this cycle.
REQ-009 SHALL have port tx_ready, output, 1 bit: FIFO can accept a byte this cycle.
REQ-010 SHALL have port TxD, output, 1 bit: serial line, idle high, registered.
REQ-011 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-012 SHALL have port fifo_count, output, clog2(FIFO_DEPTH)+1 bits: number of queued bytes, excluding the byte in flight.

Function
REQ-013 SHALL accept a byte when tx_valid && tx_ready at a clk edge; the byte is written at the FIFO write pointer and fifo_count increments.
REQ-014 SHALL drive tx_ready = rst_n && (fifo_count < FIFO_DEPTH); tx_valid while full is ignored with no state change.
REQ-015 SHALL implement the FIFO with wrap-around read and write pointers of clog2(FIFO_DEPTH) bits and preserve byte order.
REQ-016 SHALL, on a push and a pop in the same cycle, perform both operations, leaving fifo_count unchanged; a push into an empty FIFO at the same time as an IDLE pop check is not popped that cycle.
REQ-017 SHALL implement FSM states IDLE, START, DATA, STOP, with busy = (state != IDLE).
REQ-018 SHALL, in IDLE with fifo_count > 0, pop the head byte into an 8-bit shift register, clear tick_cnt and bit_cnt, and enter START at the next edge; this does not wait for baud_tick.
REQ-019 SHALL drive TxD = 0 in START, shift_reg[0] in DATA, and 1 in IDLE and STOP, registered so TxD changes on the edge entering the state.
REQ-020 SHALL increment tick_cnt (clog2(OVERSAMPLE) bits) on each baud_tick outside IDLE; a bit ends on a baud_tick that occurs while tick_cnt == OVERSAMPLE-1, and tick_cnt then returns to 0.
REQ-021 SHALL move START to DATA at the end of a bit.
REQ-022 SHALL, in DATA, right-shift the shift register and increment bit_cnt (4 bits) at the end of each bit, sending LSB first; it moves to STOP after 8 data bits.
REQ-023 SHALL, in STOP, hold TxD high for STOP_BITS x OVERSAMPLE baud_ticks.
REQ-024 SHALL, at the end of STOP, pop the next byte and go directly to START if fifo_count > 0 (no idle gap); otherwise it goes to IDLE.
REQ-025 SHALL leave the FSM state, tick_cnt and TxD unchanged in cycles without baud_tick.
REQ-026 SHALL produce a frame of exactly (10 + STOP_BITS - 1) x OVERSAMPLE baud_ticks, 40 for the defaults, measured from the first tick after entering START.

Reset
REQ-027 SHALL, while rst_n = 0 at a clk edge, force state IDLE, TxD = 1, busy = 0, fifo_count = 0, pointers 0, tick_cnt 0, bit_cnt 0, and shift register 0.
REQ-028 SHALL keep tx_ready = 0 while rst_n = 0, and tx_ready = 1 in the first cycle after release.
REQ-029 SHALL, on reset mid-frame, abandon the frame and flush the FIFO; TxD is high at the next edge with no partial stop bit, and no bytes are retained.

Verification
REQ-030 SHALL pass the single-byte test: push 0xA5 while idle, tick every 3 clk -> TxD = 0, 1,0,1,0,0,1,0,1, then 1, each held 4 ticks, busy for 40 ticks, then IDLE.
REQ-031 SHALL pass the back-to-back test: push 0x55 then 0xAA -> the second start bit begins on the edge after the first stop bit ends; TxD is never idle between frames.
REQ-032 SHALL pass the full-FIFO test: push 6 bytes continuously while busy -> one byte goes in flight, 4 are queued, fifo_count = 4 and tx_ready = 0; the 6th push is held off until the next pop, and all 6 bytes are transmitted in order.
REQ-033 SHALL pass the simultaneous push/pop test: FIFO count 2 and push on the STOP-to-START pop edge -> fifo_count stays 2, and the order is preserved.
REQ-034 SHALL pass the mid-frame reset test: assert rst_n = 0 for 1 clk during DATA bit 3 with 2 bytes queued -> TxD = 1, fifo_count = 0, busy = 0, and no further frames.
REQ-035 SHALL pass the loopback test: TxD connected to the receiver's RxD with a shared baud_tick, bytes 0x00, 0xFF, 0x3C -> the receiver reports each byte once with data_ready, with values matching.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8N1/8N2 UART transmitter paced by an oversampled baud tick.
module uart_tx #(
   parameter int OVERSAMPLE = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int STOP_BITS  = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          baud_tick,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          TxD,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(OVERSAMPLE);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t state, state_nx;
   logic [7:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [TW-1:0] tick_cnt;
   logic [3:0] bit_cnt;
   logic [7:0] shift_reg;
   logic push, pop, bit_end, has_data, txd_nx;
   // depth is a power of two, so the count MSB alone means full
   assign tx_ready = rst_n && !fifo_count[AW];
   assign push     = tx_valid && tx_ready;
   assign has_data = fifo_count != '0;
   assign bit_end  = baud_tick && tick_cnt == TW'(OVERSAMPLE - 1);
   assign busy     = state != IDLE;
   always_comb begin
      state_nx = state;
      pop = 1'b0;
      txd_nx = TxD;
      unique case (state)
         IDLE: if (has_data) begin
            state_nx = START;
            pop = 1'b1;
            txd_nx = 1'b0;
         end
         START: if (bit_end) begin
            state_nx = DATA;
            txd_nx = shift_reg[0];
         end
         DATA: if (bit_end) begin
            state_nx = bit_cnt == 4'd7 ? STOP : DATA;
            txd_nx = bit_cnt == 4'd7 ? 1'b1 : shift_reg[1];
         end
         STOP: if (bit_end && bit_cnt == 4'(STOP_BITS - 1)) begin
            state_nx = has_data ? START : IDLE;
            pop = has_data;
            txd_nx = !has_data;
         end
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         TxD <= 1'b1;
      end else begin
         state <= state_nx;
         TxD <= txd_nx;
      end
   end
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= tx_data;
   // bit_cnt counts data bits in DATA and is reused to count stop bits in STOP
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fifo_count <= '0;
         tick_cnt <= '0;
         bit_cnt <= '0;
         shift_reg <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         if (push != pop) fifo_count <= push ? fifo_count + CW'(1) : fifo_count - CW'(1);
         if (pop) begin
            shift_reg <= mem[rd_ptr];
            tick_cnt <= '0;
            bit_cnt <= '0;
         end else if (baud_tick && state != IDLE) begin
            tick_cnt <= bit_end ? '0 : tick_cnt + TW'(1);
            if (bit_end && state == DATA) begin
               shift_reg <= shift_reg >> 1;
               bit_cnt <= bit_cnt == 4'd7 ? 4'd0 : bit_cnt + 4'd1;
            end
            if (bit_end && state == STOP) bit_cnt <= bit_cnt + 4'd1;
         end
      end
   end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench; a TxD decoder on the shared baud tick checks every frame against a byte scoreboard.
module tb_uart_tx;
   logic clk = 1'b0, rst_n = 1'b0, baud_tick = 1'b0, tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic tx_ready, TxD, busy;
   logic [2:0] fifo_count;
   int n_assert = 0, n_fail = 0;
   logic [7:0] exp_q[$];
   int frames_done = 0, frames_started = 0, mon_n = 0, tick_no = 0, start_tick = 0, prev_start = 0;
   bit mon_on = 1'b0;
   logic [39:0] obs_f = '1;
   logic bsy_ok = 1'b0;
   logic [7:0] cur = 8'h00;

   uart_tx dut (
      .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .TxD(TxD), .busy(busy), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // 40 baud ticks: start bit, 8 data bits LSB first, one stop bit, each held 4 ticks
   function automatic logic [39:0] frame_of(input logic [7:0] b);
      logic [39:0] f;
      for (int t = 0; t < 40; t++) f[t] = t < 4 ? 1'b0 : (t >= 36 ? 1'b1 : b[(t - 4) / 4]);
      return f;
   endfunction

   initial begin : tick_gen
      int tc;
      tc = 0;
      forever begin
         @(posedge clk);
         #1;
         tc = tc == 2 ? 0 : tc + 1;
         baud_tick = tc == 0;
      end
   end

   // receiver: samples TxD on every baud tick, acting as the loopback RxD
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (!rst_n) mon_on = 1'b0;
         else if (baud_tick) begin
            tick_no++;
            if (mon_on) begin
               obs_f[mon_n] = TxD;
               bsy_ok &= busy;
               mon_n++;
               if (mon_n == 40) begin
                  check("frame", {24'h0, obs_f}, {24'h0, frame_of(cur)});
                  check("frame_busy", bsy_ok, 1);
                  mon_on = 1'b0;
                  frames_done++;
               end
            end else if (TxD === 1'b0) begin
               mon_on = 1'b1;
               mon_n = 1;
               obs_f = '1;
               obs_f[0] = 1'b0;
               bsy_ok = busy;
               frames_started++;
               prev_start = start_tick;
               start_tick = tick_no;
               cur = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
            end
         end
      end
   end

   task automatic push(input logic [7:0] b);
      int n = 0;
      tx_data = b;
      tx_valid = 1'b1;
      @(negedge clk);
      while (!tx_ready && n < 400) begin
         n++;
         @(negedge clk);
      end
      check("push_accept", tx_ready, 1);
      exp_q.push_back(b);
      @(posedge clk);
      #1 tx_valid = 1'b0;
   endtask

   task automatic wait_frames(input int target, input int budget);
      int n = 0;
      while (frames_done < target && n < budget) begin
         @(posedge clk);
         #2;
         n++;
      end
      check("frames_done", frames_done, target);
   endtask

   task automatic wait_tick(input int idx);
      int n = 0;
      do begin
         @(posedge clk);
         #2;
         n++;
      end while (!(mon_on && mon_n == idx && baud_tick) && n < 400);
      check("tick_sync", mon_n, idx);
   endtask

   initial begin : stim
      int fs;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_txd", TxD, 1);
      check("rst_busy", busy, 0);
      check("rst_count", fifo_count, 0);
      check("rst_ready", tx_ready, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", tx_ready, 1);
      @(posedge clk);
      #1;
      // single byte
      push(8'hA5);
      check("count_after_push", fifo_count, 1);
      check("idle_before_pop", busy, 0);
      @(posedge clk);
      #1;
      check("busy_after_pop", busy, 1);
      check("count_after_pop", fifo_count, 0);
      check("start_txd", TxD, 0);
      wait_frames(1, 300);
      check("single_end_busy", busy, 0);
      check("single_end_txd", TxD, 1);
      // back-to-back
      push(8'h55);
      push(8'hAA);
      wait_frames(3, 500);
      check("b2b_gap", start_tick - prev_start, 40);
      // full FIFO
      push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
      check("full_count", fifo_count, 4);
      check("full_ready", tx_ready, 0);
      check("full_busy", busy, 1);
      push(8'h66);
      check("refill_count", fifo_count, 4);
      wait_frames(9, 1000);
      check("full_gap", start_tick - prev_start, 40);
      check("full_drained", exp_q.size(), 0);
      // simultaneous push and pop on the STOP-to-START edge
      push(8'hC1); push(8'hC2); push(8'hC3);
      check("sim_count_pre", fifo_count, 2);
      wait_tick(39);
      check("sim_count_edge", fifo_count, 2);
      tx_data = 8'hC4;
      tx_valid = 1'b1;
      exp_q.push_back(8'hC4);
      @(posedge clk);
      #1 tx_valid = 1'b0;
      check("sim_count_post", fifo_count, 2);
      check("sim_restart_txd", TxD, 0);
      wait_frames(13, 800);
      check("sim_drained", exp_q.size(), 0);
      // mid-frame reset during data bit 3
      push(8'hD1); push(8'hD2); push(8'hD3);
      check("rst_mid_count_pre", fifo_count, 2);
      wait_tick(18);
      rst_n = 1'b0;
      #1 check("rst_mid_ready", tx_ready, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      exp_q.delete();
      check("rst_mid_txd", TxD, 1);
      check("rst_mid_count", fifo_count, 0);
      check("rst_mid_busy", busy, 0);
      fs = frames_started;
      repeat (300) @(posedge clk);
      #1;
      check("rst_mid_no_frames", frames_started, fs);
      check("rst_mid_idle_txd", TxD, 1);
      // loopback
      fs = frames_started;
      push(8'h00); push(8'hFF); push(8'h3C);
      wait_frames(16, 600);
      repeat (150) @(posedge clk);
      #1;
      check("loop_once", frames_started - fs, 3);
      check("loop_drained", exp_q.size(), 0);
      check("loop_idle", busy, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
